// File: rtl/spi_regfile_rw_if.sv
// SPI pin bundle for the register-file peripheral.
// The controller side drives the clock, select and data-out lines.
// The peripheral side returns CIPO together with its pad enable.
interface spi_regfile_rw_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output ncs,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: SPI mode-0 register-file peripheral with read-back.
// A frame is one rw bit, then the address, then the data, all MSB first.
// A write commits only when the frame has exactly the right length and
// the address exists. Every other frame is rejected with an error pulse.
// The SPI pins are asynchronous and are resynchronised onto clk.
module spi_regfile_rw #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_rw_if.slave            spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat_o,
  output logic                       wr_pulse_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       err_pulse_o
);

  localparam int CMD_BITS = 1 + ADDR_W;
  localparam int FRAME    = 1 + ADDR_W + DATA_W;
  localparam int CNT_W    = $clog2(FRAME + 2);

  localparam logic [CNT_W-1:0] CNT_CMD_DONE = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME + 1);
  localparam logic [ADDR_W:0]  REG_LIMIT    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    FULL,
    OVERRUN
  } stateE;

  // Synchroniser chains: index 0 is the first stage.
  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] ncsSync_q;
  logic [SYNC_STAGES-1:0] copiSync_q;
  logic                   sclkPrev_q;
  logic                   ncsPrev_q;

  logic sclkSync;
  logic ncsSync;
  logic copiSync;
  logic sclkRise;
  logic ncsRise;
  logic ncsFall;

  // Frame state
  stateE             state_q, state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;

  // Register file and status outputs
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wrPulse_q, wrPulse_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic              errPulse_q, errPulse_d;

  logic [CNT_W-1:0]  cntInc;
  logic              addrInRange;

  // Bring the SPI pins onto clk. One extra flop on sclk and ncs gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync_q <= '0;
      ncsSync_q  <= '1;
      copiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      ncsPrev_q  <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi.sclk};
      ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], spi.ncs};
      copiSync_q <= {copiSync_q[SYNC_STAGES-2:0], spi.copi};
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
      ncsPrev_q  <= ncsSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkSync    = sclkSync_q[SYNC_STAGES-1];
  assign ncsSync     = ncsSync_q[SYNC_STAGES-1];
  assign copiSync    = copiSync_q[SYNC_STAGES-1];
  assign sclkRise    = sclkSync & ~sclkPrev_q;
  assign ncsRise     = ncsSync & ~ncsPrev_q;
  assign ncsFall     = ~ncsSync & ncsPrev_q;
  assign cntInc      = bitCnt_q + CNT_W'(1);
  assign addrInRange = ({1'b0, addr_q} < REG_LIMIT);

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing, bit capture, read shadow and the commit/reject decision at ncs rise
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    shadow_d   = shadow_q;
    regs_d     = regs_q;
    wrPulse_d  = 1'b0;
    wrAddr_d   = wrAddr_q;
    errPulse_d = 1'b0;

    if (state_q == IDLE) begin
      if (ncsFall) begin
        state_d  = CMD;
        bitCnt_d = '0;
        rw_d     = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        shadow_d = '0;
      end
    end else if (ncsRise) begin
      // Chip select release takes priority over any sclk edge seen in the same cycle.
      state_d = IDLE;
      if ((state_q == FULL) && addrInRange) begin
        if (rw_q) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == ADDR_W'(k)) begin
              regs_d[k] = data_q;
            end
          end
          wrPulse_d = 1'b1;
          wrAddr_d  = addr_q;
        end
      end else begin
        errPulse_d = 1'b1;
      end
    end else if (sclkRise) begin
      case (state_q)
        CMD: begin
          bitCnt_d = cntInc;
          if (bitCnt_q == '0) begin
            rw_d = copiSync;
          end
          for (int i = 0; i < ADDR_W; i++) begin
            if (bitCnt_q == CNT_W'(ADDR_W - i)) begin
              addr_d[i] = copiSync;
            end
          end
          if (cntInc == CNT_CMD_DONE) begin
            state_d  = DATA;
            shadow_d = '0;
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_d == ADDR_W'(k)) begin
                shadow_d = regs_q[k];
              end
            end
          end
        end
        DATA: begin
          bitCnt_d = cntInc;
          for (int i = 0; i < DATA_W; i++) begin
            if (bitCnt_q == CNT_W'(FRAME - 1 - i)) begin
              data_d[i] = copiSync;
            end
          end
          shadow_d = {shadow_q[DATA_W-2:0], 1'b0};
          if (cntInc == CNT_FRAME) begin
            state_d = FULL;
          end
        end
        FULL: begin
          state_d  = OVERRUN;
          bitCnt_d = CNT_SAT;
        end
        default: begin
        end
      endcase
    end
  end

  // Frame datapath, register file and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitCnt_q   <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      shadow_q   <= '0;
      regs_q     <= '{default: '0};
      wrPulse_q  <= 1'b0;
      wrAddr_q   <= '0;
      errPulse_q <= 1'b0;
    end else begin
      bitCnt_q   <= bitCnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      shadow_q   <= shadow_d;
      regs_q     <= regs_d;
      wrPulse_q  <= wrPulse_d;
      wrAddr_q   <= wrAddr_d;
      errPulse_q <= errPulse_d;
    end
  end

  // Flatten the register file for the downstream configuration logic
  always_comb begin
    regs_flat_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_flat_o[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  assign spi.cipo_oe = ~ncsSync & ~rw_q & ((state_q == DATA) || (state_q == FULL));
  assign spi.cipo    = spi.cipo_oe & shadow_q[DATA_W-1];
  assign wr_pulse_o  = wrPulse_q;
  assign wr_addr_o   = wrAddr_q;
  assign err_pulse_o = errPulse_q;

endmodule
